// File: rtl/adder_share_arb.sv
// Round-robin sharing of one external pipelined adder between two requesters,
// with per-requester outstanding caps. Define ADDER_SHARE_ARB_STATS_EN for grant counters.
module adder_share_arb #(
  parameter int WIDTH   = 4,
  parameter int LAT     = 2,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             req0,
  input  logic [WIDTH-1:0] dataA0,
  input  logic [WIDTH-1:0] dataB0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dataA1,
  input  logic [WIDTH-1:0] dataB1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] add_dataA,
  output logic [WIDTH-1:0] add_dataB,
  output logic             add_valid,
  input  logic [WIDTH-1:0] add_sum,
  output logic             done0,
  output logic [WIDTH-1:0] result0,
  output logic             done1,
  output logic [WIDTH-1:0] result1
`ifdef ADDER_SHARE_ARB_STATS_EN
  ,
  output logic [7:0]       gcount0,
  output logic [7:0]       gcount1
`endif
);

  localparam int CNT_W = 3;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  // Entry 0 is written on the launch edge; entry LAT lines up with add_sum.
  tag_t [LAT:0]     tag_q, tag_d;
  tag_t             head;

  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_valid_q, add_valid_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [WIDTH-1:0] result0_q, result0_d;
  logic [WIDTH-1:0] result1_q, result1_d;
  logic [CNT_W-1:0] out0_q, out0_d;
  logic [CNT_W-1:0] out1_q, out1_d;
  logic             last_q, last_d;

  logic             elig0, elig1;
  logic             issue0, issue1;
  logic             cmp0, cmp1;

  assign head = tag_q[LAT];
  assign cmp0 = head.valid && !head.id;
  assign cmp1 = head.valid &&  head.id;

  // Eligibility deliberately uses the registered count, so a slot freed this edge is not reused until next cycle.
  always_comb begin
    elig0 = req0 && (out0_q < CNT_W'(MAX_OUT));
    elig1 = req1 && (out1_q < CNT_W'(MAX_OUT));
    gnt0  = elig0 && (!elig1 ||  last_q);
    gnt1  = elig1 && (!elig0 || !last_q);
  end

  assign issue0 = gnt0;
  assign issue1 = gnt1;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_valid_d = issue0 || issue1;
    last_d      = last_q;
    tag_d       = tag_q;
    done0_d     = cmp0;
    done1_d     = cmp1;
    result0_d   = result0_q;
    result1_d   = result1_q;
    out0_d      = out0_q;
    out1_d      = out1_q;

    if (issue0) begin
      add_a_d = dataA0;
      add_b_d = dataB0;
      last_d  = 1'b0;
    end else if (issue1) begin
      add_a_d = dataA1;
      add_b_d = dataB1;
      last_d  = 1'b1;
    end

    tag_d[0].valid = issue0 || issue1;
    tag_d[0].id    = issue1;
    for (int i = 1; i <= LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    if (cmp0) result0_d = add_sum;
    if (cmp1) result1_d = add_sum;

    unique case ({issue0, cmp0})
      2'b10:   out0_d = out0_q + CNT_W'(1);
      2'b01:   out0_d = out0_q - CNT_W'(1);
      default: out0_d = out0_q;
    endcase

    unique case ({issue1, cmp1})
      2'b10:   out1_d = out1_q + CNT_W'(1);
      2'b01:   out1_d = out1_q - CNT_W'(1);
      default: out1_d = out1_q;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_valid_q <= 1'b0;
      // NOTE: the tag pipeline is reset on purpose: stale ownership after reset would fire bogus done pulses.
      tag_q       <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      result0_q   <= '0;
      result1_q   <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      last_q      <= 1'b1;
    end else begin
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_valid_q <= add_valid_d;
      tag_q       <= tag_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      result0_q   <= result0_d;
      result1_q   <= result1_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      last_q      <= last_d;
    end
  end

  assign add_dataA = add_a_q;
  assign add_dataB = add_b_q;
  assign add_valid = add_valid_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign result0   = result0_q;
  assign result1   = result1_q;

`ifdef ADDER_SHARE_ARB_STATS_EN
  logic [7:0] gcount0_q, gcount0_d;
  logic [7:0] gcount1_q, gcount1_d;

  always_comb begin
    gcount0_d = gcount0_q;
    gcount1_d = gcount1_q;
    if (issue0 && gcount0_q != 8'hFF) gcount0_d = gcount0_q + 8'd1;
    if (issue1 && gcount1_q != 8'hFF) gcount1_d = gcount1_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      gcount0_q <= '0;
      gcount1_q <= '0;
    end else begin
      gcount0_q <= gcount0_d;
      gcount1_q <= gcount1_d;
    end
  end

  assign gcount0 = gcount0_q;
  assign gcount1 = gcount1_q;
`endif

  a_one_grant: assert property (@(posedge clk) disable iff (!reset_L) !(gnt0 && gnt1));
  a_cap0:      assert property (@(posedge clk) disable iff (!reset_L) out0_q <= CNT_W'(MAX_OUT));
  a_cap1:      assert property (@(posedge clk) disable iff (!reset_L) out1_q <= CNT_W'(MAX_OUT));

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for adder_share_arb with a behavioural two-stage adder.
// Exercises the ADDER_SHARE_ARB_STATS_EN counters when that macro is defined.
module tb_adder_share_arb;

  localparam int WIDTH   = 4;
  localparam int MAX_OUT = 2;

  logic             clk = 1'b0;
  logic             reset_L;
  logic             req0, req1;
  logic [WIDTH-1:0] dataA0, dataB0, dataA1, dataB1;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] add_dataA, add_dataB, add_sum;
  logic             add_valid;
  logic             done0, done1;
  logic [WIDTH-1:0] result0, result1;
`ifdef ADDER_SHARE_ARB_STATS_EN
  logic [7:0]       gcount0, gcount1;
`endif

  adder_share_arb #(.WIDTH(WIDTH), .LAT(2), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset_L(reset_L),
    .req0(req0), .dataA0(dataA0), .dataB0(dataB0),
    .req1(req1), .dataA1(dataA1), .dataB1(dataB1),
    .gnt0(gnt0), .gnt1(gnt1),
    .add_dataA(add_dataA), .add_dataB(add_dataB), .add_valid(add_valid),
    .add_sum(add_sum),
    .done0(done0), .result0(result0), .done1(done1), .result1(result1)
`ifdef ADDER_SHARE_ARB_STATS_EN
    , .gcount0(gcount0), .gcount1(gcount1)
`endif
  );

  always #5 clk = ~clk;

  // Two register stages: sum valid two edges after the operands launch.
  logic [WIDTH-1:0] s1, s2;
  always @(posedge clk) begin
    s1 <= add_dataA + add_dataB;
    s2 <= s1;
  end
  assign add_sum = s2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] sum;
    int               issue_cyc;
  } exp_t;

  exp_t             q0[$], q1[$];
  logic             pend_v;
  logic [WIDTH-1:0] pend_a, pend_b;
  int               outst0, outst1;

  // Mid-cycle monitor: scoreboard push on grant, pop and compare on done.
  always @(negedge clk) begin
    if (!reset_L) begin
      q0.delete();
      q1.delete();
      pend_v = 1'b0;
      outst0 = 0;
      outst1 = 0;
    end else begin
      exp_t e;
      logic [WIDTH-1:0] s;
      check("add_valid", add_valid, pend_v);
      if (pend_v) begin
        check("add_dataA", add_dataA, pend_a);
        check("add_dataB", add_dataB, pend_b);
      end
      if (done0) begin
        check("done0_expected", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check("result0", result0, e.sum);
          check("latency0", cyc - e.issue_cyc, 3);
          outst0--;
        end
      end
      if (done1) begin
        check("done1_expected", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("result1", result1, e.sum);
          check("latency1", cyc - e.issue_cyc, 3);
          outst1--;
        end
      end
      check("gnt_exclusive", gnt0 && gnt1, 0);
      check("gnt0_needs_req", gnt0 && !req0, 0);
      check("gnt1_needs_req", gnt1 && !req1, 0);
      pend_v = 1'b0;
      if (req0 && gnt0) begin
        s = dataA0 + dataB0;
        q0.push_back('{sum: s, issue_cyc: cyc + 1});
        pend_v = 1'b1; pend_a = dataA0; pend_b = dataB0;
        outst0++;
      end else if (req1 && gnt1) begin
        s = dataA1 + dataB1;
        q1.push_back('{sum: s, issue_cyc: cyc + 1});
        pend_v = 1'b1; pend_a = dataA1; pend_b = dataB1;
        outst1++;
      end
      check("outst0_cap", outst0 <= MAX_OUT, 1);
      check("outst1_cap", outst1 <= MAX_OUT, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                       input logic r1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    req0 = r0; dataA0 = a0; dataB0 = b0;
    req1 = r1; dataA1 = a1; dataB1 = b1;
  endtask

  task automatic wait_idle(input int budget);
    bit idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (q0.size() == 0 && q1.size() == 0 && !pend_v) begin
        idle = 1'b1;
        break;
      end
    end
    check("idle_within_budget", idle, 1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_add_valid"}, add_valid, 0);
    check({tag, "_add_dataA"}, add_dataA, 0);
    check({tag, "_add_dataB"}, add_dataB, 0);
    check({tag, "_done0"},     done0, 0);
    check({tag, "_done1"},     done1, 0);
    check({tag, "_result0"},   result0, 0);
    check({tag, "_result1"},   result1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;

    // Single op: 3 + 5 -> 8 on requester 0.
    drive(1, 3, 5, 0, 0, 0);
    #2;
    check("single_gnt0", gnt0, 1);
    check("single_gnt1", gnt1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wait_idle(20);
    check("single_result0", result0, 8);
    check("single_result1", result1, 0);

    // Modular wrap on requester 1.
    drive(0, 0, 0, 1, 9, 9);
    #2;
    check("wrap_gnt1_a", gnt1, 1);
    tick();
    drive(0, 0, 0, 1, 15, 1);
    #2;
    check("wrap_gnt1_b", gnt1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wait_idle(20);
    check("wrap_result1", result1, 0);

    // Contention: strict alternation starting with requester 0.
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'($urandom), 4'($urandom), 1, 4'($urandom), 4'($urandom));
      #2;
      check("cont_gnt0", gnt0, (i % 2) == 0);
      check("cont_gnt1", gnt1, (i % 2) == 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    wait_idle(30);

    // Credit cap: two grants, then wait two cycles for the first done.
    for (int i = 0; i < 12; i++) begin
      drive(1, 4'($urandom), 4'($urandom), 0, 0, 0);
      #2;
      check("cap_gnt0", gnt0, (i % 4) < 2);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    wait_idle(30);

    // Async reset with two operations in flight.
    drive(1, 2, 7, 0, 0, 0);
    tick();
    drive(1, 4, 4, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    reset_L = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 reset_L = 1'b1;
    repeat (6) tick();
    check("post_reset_no_done0", done0, 0);

    // First contention after reset goes to requester 0.
    drive(1, 6, 6, 1, 1, 2);
    #2;
    check("post_reset_gnt0", gnt0, 1);
    check("post_reset_gnt1", gnt1, 0);
    tick();
    #2;
    check("post_reset_gnt1_next", gnt1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wait_idle(20);
    check("post_reset_result0", result0, 12);
    check("post_reset_result1", result1, 3);

`ifdef ADDER_SHARE_ARB_STATS_EN
    begin
      int n = 0;
      reset_L = 1'b0;
      #1;
      check("stats_reset_g0", gcount0, 0);
      check("stats_reset_g1", gcount1, 0);
      @(posedge clk);
      #1 reset_L = 1'b1;
      for (int i = 0; i < 2000 && n < 300; i++) begin
        drive(1, 4'($urandom), 4'($urandom), 0, 0, 0);
        #2;
        if (gnt0) n++;
        tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      check("stats_grants_reached", n, 300);
      wait_idle(20);
      check("stats_gcount0_sat", gcount0, 255);
      check("stats_gcount1", gcount1, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
